// File: rtl/player_input_if.sv
// Player control bus: frame strobe and raw buttons in, conditioned command levels out.
// The conditioner (player_input_ctrl) takes the slave side; the driver of buttons and
// frame ticks, plus the consumer of the command levels, takes the master side.
interface player_input_if;
  logic       frame_tick;
  logic [4:0] btn_raw;
  logic       right;
  logic       left;
  logic       jump;
  logic       squat;
  logic       defend;

  modport master (output frame_tick, btn_raw,
                  input  right, left, jump, squat, defend);
  modport slave  (input  frame_tick, btn_raw,
                  output right, left, jump, squat, defend);
endinterface

// File: rtl/player_input_ctrl.sv
// player_input_ctrl: synchronise, debounce and resolve one player's five buttons,
// presenting frame-aligned right/left/jump/squat/defend levels downstream.
// Optional feature macro: PLAYER_INPUT_JUMP_REPEAT_EN. When defined, a held jump
// button requests a jump on every frame tick. When undefined, each debounced press
// yields one jump frame.

// Per-button lane: polarity fix, 2-flop synchroniser, debounce counter.
module player_input_lane #(
  parameter logic [15:0] DEBOUNCE_CYC   = 16'd50000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o
);
  logic        pressed;
  logic [1:0]  sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic        db_q, db_d;

  assign pressed = BTN_ACTIVE_LOW ? ~raw_i : raw_i;

  // Two-flop synchroniser; sync_q[1] is the clean sample.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], pressed};

  // Any match clears the run; DEBOUNCE_CYC consecutive mismatches flip db.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_q[1] != db_q) begin
      if (cnt_q == DEBOUNCE_CYC - 16'd1) db_d  = ~db_q;
      else                               cnt_d = cnt_q + 16'd1;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end

  assign db_o = db_q;
endmodule

module player_input_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYC   = 16'd50000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  player_input_if.slave  bus
);
  localparam int NUM_BTN  = 5;
  localparam int B_RIGHT  = 0;
  localparam int B_LEFT   = 1;
  localparam int B_JUMP   = 2;
  localparam int B_SQUAT  = 3;
  localparam int B_DEFEND = 4;

  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_R = 2'd1, DIR_L = 2'd2} dir_e;

  logic [NUM_BTN-1:0] db;
  logic [2:0]         db_prev_q;
  logic [2:0]         rise;
  dir_e               dir_q, dir_d;
  logic               jump_pend_q, jump_pend_d;
  logic               jump_src;
  logic [NUM_BTN-1:0] out_q, out_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    player_input_lane #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .raw_i(bus.btn_raw[g]),
      .db_o (db[g])
    );
  end

  // Rising edges of the debounced right/left/jump levels.
  assign rise = db[2:0] & ~db_prev_q;

`ifdef PLAYER_INPUT_JUMP_REPEAT_EN
  assign jump_src = db[B_JUMP];
`else
  assign jump_src = rise[B_JUMP];
`endif

  // Direction state register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dir_q <= DIR_NONE;
    else        dir_q <= dir_d;

  // Last-pressed wins; a simultaneous press of both keeps the current choice,
  // releasing the selected side falls back to the other side if still held.
  always_comb begin
    dir_d = dir_q;
    if (rise[B_RIGHT] && !rise[B_LEFT])              dir_d = DIR_R;
    else if (rise[B_LEFT] && !rise[B_RIGHT])         dir_d = DIR_L;
    else if (dir_q == DIR_R && !db[B_RIGHT])         dir_d = db[B_LEFT]  ? DIR_L : DIR_NONE;
    else if (dir_q == DIR_L && !db[B_LEFT])          dir_d = db[B_RIGHT] ? DIR_R : DIR_NONE;
  end

  // Jump latch: a tick consumes the pending request; an edge landing on that
  // same tick is consumed only if nothing was already pending.
  always_comb begin
    jump_pend_d = jump_pend_q | rise[B_JUMP];
    if (bus.frame_tick) jump_pend_d = jump_pend_q & rise[B_JUMP];
  end

  // Frame-aligned output values; hold between ticks.
  always_comb begin
    out_d = out_q;
    if (bus.frame_tick) begin
      out_d[B_RIGHT]  = (dir_q == DIR_R);
      out_d[B_LEFT]   = (dir_q == DIR_L);
      out_d[B_JUMP]   = jump_pend_q | jump_src;
      out_d[B_SQUAT]  = db[B_SQUAT];
      out_d[B_DEFEND] = db[B_DEFEND];
    end
  end

  // Edge history, jump latch and output registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      db_prev_q   <= '0;
      jump_pend_q <= 1'b0;
      out_q       <= '0;
    end else begin
      db_prev_q   <= db[2:0];
      jump_pend_q <= jump_pend_d;
      out_q       <= out_d;
    end

  assign bus.right  = out_q[B_RIGHT];
  assign bus.left   = out_q[B_LEFT];
  assign bus.jump   = out_q[B_JUMP];
  assign bus.squat  = out_q[B_SQUAT];
  assign bus.defend = out_q[B_DEFEND];
endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: DEBOUNCE_CYC=4, active-low buttons, tick every 20 clk.
// A history-based reference model is compared every cycle; a vector table and a few
// hand sequences check settled behaviour and corner cases.
module tb_player_input_ctrl;
  localparam int D        = 4;
  localparam int TICK_PER = 20;
`ifdef PLAYER_INPUT_JUMP_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] press = 5'h1f;   // active-high "pressed", bit order as btn_raw
  logic       tick  = 1'b0;
  int         tcnt  = 0;
  int         errs  = 0;
  int         checks = 0;

  player_input_if bus();
  assign bus.btn_raw    = ~press;
  assign bus.frame_tick = tick;

  player_input_ctrl #(.DEBOUNCE_CYC(16'd4), .BTN_ACTIVE_LOW(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcnt = (tcnt + 1) % TICK_PER;
    tick = (tcnt == 0);
  end

  // ---------------- reference model ----------------
  logic [4:0] m_out = '0;
  logic [4:0] m_db  = '0;
  logic [4:0] m_dbp = '0;
  logic [4:0] m_hist[$];
  logic [4:0] m_sync[$] = '{5'd0, 5'd0};
  int         m_dir  = 0;   // 0 none, 1 right, 2 left
  int         m_jcnt = 0;   // pending jump requests (at most one carried)

  task automatic model_step();
    logic [4:0] rs, ndb;
    int tot, nd;
    logic jmp;
    rs  = m_db & ~m_dbp;
    tot = m_jcnt + int'(rs[2]);
    if (tick) begin
      jmp    = (tot > 0) | (REP & m_db[2]);
      m_out  = {m_db[4], m_db[3], jmp, 1'(m_dir == 2), 1'(m_dir == 1)};
      m_jcnt = (tot > 0) ? tot - 1 : 0;
    end else begin
      m_jcnt = (tot > 1) ? 1 : tot;
    end
    if (rs[0] && !rs[1])                  nd = 1;
    else if (rs[1] && !rs[0])             nd = 2;
    else if (m_dir == 1 && !m_db[0])      nd = m_db[1] ? 2 : 0;
    else if (m_dir == 2 && !m_db[1])      nd = m_db[0] ? 1 : 0;
    else                                  nd = m_dir;
    m_dir = nd;
    m_dbp = m_db;
    // db flips once the last D synchronised samples all disagree with it
    m_hist.push_back(m_sync[0]);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    ndb = m_db;
    if (m_hist.size() == D)
      for (int b = 0; b < 5; b++) begin
        bit all;
        all = 1'b1;
        foreach (m_hist[k]) if (m_hist[k][b] == m_db[b]) all = 1'b0;
        if (all) ndb[b] = ~m_db[b];
      end
    m_db = ndb;
    void'(m_sync.pop_front());
    m_sync.push_back(press);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_db = '0; m_dbp = '0; m_hist.delete();
      m_sync = '{5'd0, 5'd0}; m_dir = 0; m_jcnt = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [4:0] outs();
    return {bus.defend, bus.squat, bus.jump, bus.left, bus.right};
  endfunction

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance n cycles, comparing against the model at each negedge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("model", outs(), m_out);
    end
  endtask

  typedef struct {
    string      name;
    logic [4:0] prs;
    int         cyc;
    logic [4:0] exp;   // jump column filled from REP below
  } vec_t;

  vec_t tbl[$];

  initial begin
    int jc;
    logic [4:0] e;
    // {defend,squat,jump,left,right}
    tbl = '{
      '{"idle",       5'b00000, 60, 5'b00000},
      '{"right",      5'b00001, 60, 5'b00001},
      '{"right_left", 5'b00011, 60, 5'b00010},
      '{"left_rel",   5'b00001, 60, 5'b00001},
      '{"idle2",      5'b00000, 60, 5'b00000},
      '{"left",       5'b00010, 60, 5'b00010},
      '{"left_right", 5'b00011, 60, 5'b00001},
      '{"sq_df",      5'b11000, 60, 5'b11000},
      '{"sq_only",    5'b01000, 60, 5'b01000},
      '{"jump_hold",  5'b00100, 60, 5'b00000},
      '{"idle3",      5'b00000, 60, 5'b00000},
      '{"all_same",   5'b11111, 60, 5'b11000}
    };

    // Reset with every button pressed: outputs stay 0.
    run(10);
    chk("reset_outs", outs(), 5'b00000);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run(1);
      chk("post_reset_quiet", outs(), 5'b00000);
    end
    run(60);
    chk("reset_release", outs(), {2'b11, REP, 2'b00});

    // Settled-state vectors.
    foreach (tbl[i]) begin
      press = tbl[i].prs;
      run(tbl[i].cyc);
      e = tbl[i].exp;
      e[2] = REP & tbl[i].prs[2];
      chk(tbl[i].name, outs(), e);
    end

    // Bounce on right: never long enough to debounce.
    press = '0;
    run(60);
    for (int i = 0; i < 15; i++) begin
      press[0] = ~press[0];
      for (int k = 0; k < 2; k++) begin
        run(1);
        chk_int("bounce_right", int'(bus.right), 0);
      end
    end
    press = '0;
    for (int i = 0; i < 40; i++) begin
      run(1);
      chk_int("bounce_settle", int'(bus.right), 0);
    end

    // Conflict: right held, left added, left released.
    press = 5'b00001;
    run(50);
    chk("conflict_right", outs(), 5'b00001);
    press = 5'b00011;
    run(7);
    chk("conflict_before_tick", outs(), 5'b00001);
    run(40);
    chk("conflict_left", outs(), 5'b00010);
    press = 5'b00001;
    run(40);
    chk("conflict_back_right", outs(), 5'b00001);
    press = '0;
    run(60);

    // Short jump: one frame exactly.
    jc = 0;
    press[2] = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 8) press[2] = 1'b0;
      run(1);
      if (bus.jump) jc++;
    end
    chk_int("short_jump_cycles", jc, TICK_PER);

    // Held jump for 100 cycles.
    jc = 0;
    press[2] = 1'b1;
    for (int i = 0; i < 140; i++) begin
      if (i == 100) press[2] = 1'b0;
      run(1);
      if (bus.jump) jc++;
    end
    if (REP) chk_int("held_jump_repeat", int'(jc >= 80 && jc <= 120), 1);
    else     chk_int("held_jump_single", jc, TICK_PER);

    // Random stimulus against the model, with one asynchronous reset mid-run.
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 3) == 0) press = 5'($urandom);
      else press[$urandom_range(0, 4)] ^= 1'b1;
      run($urandom_range(1, 12));
      if (s == 150) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset", outs(), 5'b00000);
        run(3);
        rst_n = 1'b1;
      end
    end
    press = '0;
    run(60);
    chk("final_idle", outs(), 5'b00000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
